// File: rtl/logits_argmax.sv
// logits_argmax: top-1 search over a flattened logit vector.
// A trigger (start or logits_valid) in IDLE snapshots the whole vector.
// The snapshot is then scanned LANES elements per cycle. The index and score
// of the largest signed logit are registered, with ties going to the lowest index.
// Optional feature macro: LOGITS_ARGMAX_MARGIN_EN adds the runner-up index and
// the top-1 minus runner-up margin as outputs.
module logits_argmax #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 1000,
    parameter int LANES       = 8,
    parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              logits_valid,
    input  logic [DATA_WIDTH*NUM_CLASSES-1:0] logits_in,
    output logic                              busy,
    output logic                              done,
    output logic                              out_valid,
    output logic [IDX_W-1:0]                  class_idx,
    output logic [DATA_WIDTH-1:0]             class_score
`ifdef LOGITS_ARGMAX_MARGIN_EN
    ,
    output logic [IDX_W-1:0]                  second_idx,
    output logic [DATA_WIDTH:0]               margin
`endif
);

    localparam int NCHUNK = (NUM_CLASSES + LANES - 1) / LANES;
    localparam int TOT    = NCHUNK * LANES;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                        state, state_nxt;
    logic                          trigger;
    logic                          last_chunk;
    logic [CNT_W-1:0]              cnt;
    // Padded snapshot; shifts down by LANES each scan cycle so lane l always reads snap[l]
    logic signed [DATA_WIDTH-1:0]  snap [TOT];

    logic signed [DATA_WIDTH-1:0]  best_score, nb_score;
    logic [IDX_W-1:0]              best_idx, nb_idx;
    logic                          best_found, nb_found;
`ifdef LOGITS_ARGMAX_MARGIN_EN
    logic signed [DATA_WIDTH-1:0]  sec_score, ns_score;
    logic [IDX_W-1:0]              sec_idx, ns_idx;
    logic                          sec_found, ns_found;

    // Sign-extended difference; non-negative because hi is the maximum
    function automatic logic [DATA_WIDTH:0] calc_margin(input logic signed [DATA_WIDTH-1:0] hi,
                                                        input logic signed [DATA_WIDTH-1:0] lo);
        logic signed [DATA_WIDTH:0] d;
        d = {hi[DATA_WIDTH-1], hi} - {lo[DATA_WIDTH-1], lo};
        return d;
    endfunction
`endif

    assign trigger    = start | logits_valid;
    assign last_chunk = (cnt == CNT_W'(NCHUNK - 1));
    assign busy       = (state == SCAN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; triggers outside IDLE are dropped
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = SCAN;
            SCAN:    if (last_chunk) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fold the current chunk into the running best (and runner-up) in index order
    always_comb begin
        nb_score = best_score;
        nb_idx   = best_idx;
        nb_found = best_found;
`ifdef LOGITS_ARGMAX_MARGIN_EN
        ns_score = sec_score;
        ns_idx   = sec_idx;
        ns_found = sec_found;
`endif
        for (int l = 0; l < LANES; l++) begin
            if (int'(cnt) * LANES + l < NUM_CLASSES) begin
                if (!nb_found) begin
                    nb_score = snap[l];
                    nb_idx   = IDX_W'(int'(cnt) * LANES + l);
                    nb_found = 1'b1;
                end else if (snap[l] > nb_score) begin
`ifdef LOGITS_ARGMAX_MARGIN_EN
                    ns_score = nb_score;
                    ns_idx   = nb_idx;
                    ns_found = 1'b1;
`endif
                    nb_score = snap[l];
                    nb_idx   = IDX_W'(int'(cnt) * LANES + l);
                end
`ifdef LOGITS_ARGMAX_MARGIN_EN
                else if (!ns_found || snap[l] > ns_score) begin
                    ns_score = snap[l];
                    ns_idx   = IDX_W'(int'(cnt) * LANES + l);
                    ns_found = 1'b1;
                end
`endif
            end
        end
    end

    // Snapshot, chunk counter and running best registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TOT; k++) snap[k] <= '0;
            cnt        <= '0;
            best_score <= '0;
            best_idx   <= '0;
            best_found <= 1'b0;
`ifdef LOGITS_ARGMAX_MARGIN_EN
            sec_score  <= '0;
            sec_idx    <= '0;
            sec_found  <= 1'b0;
`endif
        end else if (state == IDLE && trigger) begin
            for (int k = 0; k < NUM_CLASSES; k++) snap[k] <= logits_in[k*DATA_WIDTH +: DATA_WIDTH];
            for (int k = NUM_CLASSES; k < TOT; k++) snap[k] <= '0;
            cnt        <= '0;
            best_score <= MIN_VAL;
            best_idx   <= '0;
            best_found <= 1'b0;
`ifdef LOGITS_ARGMAX_MARGIN_EN
            sec_score  <= MIN_VAL;
            sec_idx    <= '0;
            sec_found  <= 1'b0;
`endif
        end else if (state == SCAN) begin
            for (int k = 0; k < TOT - LANES; k++) snap[k] <= snap[k+LANES];
            for (int k = TOT - LANES; k < TOT; k++) snap[k] <= '0;
            cnt        <= cnt + CNT_W'(1);
            best_score <= nb_score;
            best_idx   <= nb_idx;
            best_found <= nb_found;
`ifdef LOGITS_ARGMAX_MARGIN_EN
            sec_score  <= ns_score;
            sec_idx    <= ns_idx;
            sec_found  <= ns_found;
`endif
        end
    end

    // Result registers: loaded on the last scan cycle so they are valid alongside done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            out_valid   <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
`ifdef LOGITS_ARGMAX_MARGIN_EN
            second_idx  <= '0;
            margin      <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE && trigger) begin
                out_valid <= 1'b0;
            end else if (state == SCAN && last_chunk) begin
                done        <= 1'b1;
                out_valid   <= 1'b1;
                class_idx   <= nb_idx;
                class_score <= nb_score;
`ifdef LOGITS_ARGMAX_MARGIN_EN
                second_idx  <= ns_found ? ns_idx : '0;
                margin      <= ns_found ? calc_margin(nb_score, ns_score) : '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_logits_argmax.sv
// Testbench for logits_argmax (NUM_CLASSES=10, LANES=4) with a result scoreboard.
module tb_logits_argmax;

    localparam int DW = 16;
    localparam int NC = 10;
    localparam int LN = 4;
    localparam int IW = 4;
    localparam int NCH = (NC + LN - 1) / LN;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              logits_valid;
    logic [DW*NC-1:0]  logits_in;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic [IW-1:0]     class_idx;
    logic [DW-1:0]     class_score;
`ifdef LOGITS_ARGMAX_MARGIN_EN
    logic [IW-1:0]     second_idx;
    logic [DW:0]       margin;
`endif

    logits_argmax #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .LANES(LN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .logits_valid(logits_valid),
        .logits_in(logits_in), .busy(busy), .done(done), .out_valid(out_valid),
        .class_idx(class_idx), .class_score(class_score)
`ifdef LOGITS_ARGMAX_MARGIN_EN
        , .second_idx(second_idx), .margin(margin)
`endif
    );

    typedef struct {
        int idx;
        int score;
        int sidx;
        int marg;
        int t;
    } exp_t;

    exp_t                  sb [$];
    logic signed [DW-1:0]  vec [NC];
    int                    checks = 0;
    int                    failures = 0;
    int                    cyc = 0;
    int                    done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW*NC-1:0] pack_vec();
        logic [DW*NC-1:0] p;
        for (int k = 0; k < NC; k++) p[k*DW +: DW] = vec[k];
        return p;
    endfunction

    // Reference: first index holding the maximum; runner-up is the best of the rest
    function automatic exp_t model();
        exp_t e;
        int bi = 0;
        int si = -1;
        for (int k = 1; k < NC; k++) if (vec[k] > vec[bi]) bi = k;
        for (int k = 0; k < NC; k++)
            if (k != bi && (si < 0 || vec[k] > vec[si])) si = k;
        e.idx   = bi;
        e.score = int'({16'h0, vec[bi]});
        e.sidx  = si;
        e.marg  = int'(vec[bi]) - int'(vec[si]);
        e.t     = 0;
        return e;
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("class_idx", 32'(class_idx), e.idx);
                check("class_score", 32'(class_score), e.score);
                check("out_valid_at_done", 32'(out_valid), 1);
                check("latency", cyc - e.t, NCH + 1);
`ifdef LOGITS_ARGMAX_MARGIN_EN
                check("second_idx", 32'(second_idx), e.sidx);
                check("margin", 32'(margin), e.marg);
`endif
            end
        end
    end

    // Drive one trigger pulse; called at posedge+1, returns one cycle later
    task automatic fire(input bit use_start, input bit expect_result);
        exp_t e;
        logits_in = pack_vec();
        if (use_start) start = 1'b1;
        else           logits_valid = 1'b1;
        if (expect_result) begin
            e = model();
            e.t = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        logits_valid = 1'b0;
        check("busy_after_trigger", 32'(busy), 1);
    endtask

    task automatic wait_done();
        int c0 = done_cnt;
        for (int i = 0; i < 30 && done_cnt == c0; i++) begin
            @(posedge clk); #1;
        end
        check("done_seen", 32'(done_cnt > c0), 1);
        check("busy_idle", 32'(busy), 0);
        check("done_one_cycle", 32'(done), 0);
        check("out_valid_held", 32'(out_valid), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        logits_valid = 1'b0;
        logits_in = '0;
        for (int k = 0; k < NC; k++) vec[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_class_idx", 32'(class_idx), 0);
        check("rst_class_score", 32'(class_score), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Tie between idx 2 and 4 resolves to 2
        vec = '{16'sd3, -16'sd1, 16'sd7, 16'sd2, 16'sd7, 16'sd0, -16'sd5, 16'sd1, 16'sd6, 16'sd4};
        fire(1'b0, 1'b1);
        wait_done();

        // All most-negative
        for (int k = 0; k < NC; k++) vec[k] = 16'sh8000;
        fire(1'b1, 1'b1);
        wait_done();

        // Max lives in the partially masked tail chunk
        for (int k = 0; k < NC; k++) vec[k] = '0;
        vec[9] = 16'sd100;
        fire(1'b1, 1'b1);
        wait_done();

        // Runner-up cases (padding at the minimum value)
        for (int k = 0; k < NC; k++) vec[k] = 16'sh8000;
        vec[0] = 16'sd5; vec[1] = 16'sd9; vec[2] = 16'sd9; vec[3] = -16'sd2;
        fire(1'b0, 1'b1);
        wait_done();
        vec[0] = -16'sd3; vec[1] = 16'sd4; vec[2] = 16'sd1; vec[3] = 16'sd0;
        fire(1'b1, 1'b1);
        wait_done();

        // Bus change after capture and a retrigger mid-scan are both ignored
        begin
            int c0;
            for (int k = 0; k < NC; k++) vec[k] = 16'(k * 3 - 10);
            c0 = done_cnt;
            fire(1'b1, 1'b1);
            for (int k = 0; k < NC; k++) vec[k] = 16'sd500;
            logits_in = pack_vec();
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            wait_done();
            repeat (6) @(posedge clk);
            #1;
            check("done_count_once", done_cnt - c0, 1);
        end

        // Asynchronous reset mid-scan kills the result
        for (int k = 0; k < NC; k++) vec[k] = 16'(k);
        fire(1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_class_idx", 32'(class_idx), 0);
        check("midrst_class_score", 32'(class_score), 0);
        check("midrst_done", 32'(done), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NC; k++) vec[k] = 16'(20 - k);
        vec[6] = 16'sd42;
        fire(1'b1, 1'b1);
        wait_done();

        // Random vectors: narrow range for ties, then full range
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NC; k++)
                vec[k] = (r < 4) ? 16'($signed($urandom_range(0, 6)) - 3) : 16'($urandom);
            fire(r[0], 1'b1);
            wait_done();
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
